seg7_scan_reader: RTL and testbench
===================================

Name: seg7_scan_reader

Overview:
- Reverse direction of the 3-bit numeric 7-segment decoder.
- Monitors a time-multiplexed 4-digit 7-segment display bus (active-low segments, active-low anodes) and recovers the 3-bit digit values 0-7 from the segment patterns.
- Debounces each digit slot and flags blank and illegal patterns.
- Emits one registered 4-digit frame per complete scan.
- Used as a display loopback checker and observer in the board-level design.

Parameters:
STABLE_CYCLES, 4, consecutive cycles the synchronized {an, seg} sample must be unchanged before capture (legal range 2..255).
TIMEOUT, 1024, idle cycles without any capture before scan_lost asserts (legal range 2..65535).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
seg_a..seg_g  input  1 each  segment lines, active-low (0 = lit).
seg_dp  input  1  decimal point, active-low; legal frames hold it at 1.
an  input  4  digit enables, active-low; an[i]=0 selects slot i.
digits  output  12  slot i value at [3i+2:3i].
blanks  output  4  slot i showed the all-off pattern.
errs  output  4  slot i showed an illegal pattern.
frame_valid  output  1  one-cycle pulse; digits/blanks/errs updated for that frame.
scan_lost  output  1  level; no capture for TIMEOUT cycles.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - Synchronizers, stability counter, capture mask and timeout counter cleared.
  - FSM in SETTLE.
- Input path: the 12-bit sample {an, seg_a..seg_g, seg_dp} passes through a 2-flop synchronizer. All further logic uses the second stage.
- Decode table, {a,b,c,d,e,f,g} with seg_dp=1:
  - 0000001 -> 0
  - 1001111 -> 1
  - 0010010 -> 2
  - 0000110 -> 3
  - 1001100 -> 4
  - 0100100 -> 5
  - 0100000 -> 6
  - 0001111 -> 7
  - 1111111 -> blank (value 0)
  - Any other pattern, or seg_dp=0 -> error (value 0).
- FSM:
  - SETTLE:
    - Stability counter increments each cycle the sample equals the previous sample; any change reloads it to 0.
    - Capture condition: counter reaches STABLE_CYCLES-1 AND exactly one an bit is 0.
    - On capture, for the selected slot: write the decoded value, blank bit and error bit into the internal slot registers, and set the slot's mask bit.
    - After capture -> HOLD.
    - If the counter reaches STABLE_CYCLES-1 with an=1111 or more than one an bit 0, there is no capture; stay in SETTLE with the counter saturated.
  - HOLD: no further capture. Any sample change -> SETTLE with the counter at 0.
- Rescan of an already-captured slot before frame completion overwrites that slot. The mask is unchanged.
- Frame completion:
  - Trigger: the capture that makes mask=1111.
  - On the next edge: digits, blanks and errs load from the slot registers, frame_valid=1 for exactly one cycle, and the mask clears.
  - Outputs hold until the next frame.
  - A capture occurring in the frame_valid cycle counts toward the new mask.
- Timeout:
  - The counter increments each cycle without a capture and saturates at TIMEOUT.
  - On reaching TIMEOUT: scan_lost=1 and the mask clears. Slot registers and outputs are unchanged.
  - Any capture clears the counter and scan_lost on the same edge.
- Latency: capture occurs STABLE_CYCLES+2 edges after an input change, with an input stable thereafter. frame_valid rises one edge after the 4th capture.
- Reset mid-frame discards partial captures. No frame_valid until 4 new captures.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> all outputs 0. Release -> outputs stay 0 and scan_lost=0 for fewer than TIMEOUT cycles.
2. Normal scan:
   - Stimulus, each step held 8 cycles with seg_dp=1:
     - an=1110 with 0000110 (3)
     - an=1101 with 0100100 (5)
     - an=1011 with 0000001 (0)
     - an=0111 with 0001111 (7)
   - Response: exactly one frame_valid pulse; digits=12'hE2B, blanks=0000, errs=0000.
3. Glitch rejection: slot 0 pattern 1001111 held STABLE_CYCLES-1 cycles, then changed -> no capture; mask and timeout counter unaffected by that slot.
4. Blank/illegal frame:
   - Slot 0 = 1111111, slot 1 = 0000000, slot 2 = 0000001 with seg_dp=0, slot 3 = 0100000.
   - Response: digits=12'hC00, blanks=0001, errs=0110.
5. Bad anodes and timeout:
   - an=0000 or 0011 held -> no capture.
   - After TIMEOUT cycles -> scan_lost=1.
   - Next valid single-anode capture -> scan_lost=0 on that edge.
6. Reset mid-frame: 2 slots captured, pulse rst_n -> full 4-slot scan needed. frame_valid appears only after the 4th new capture.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// Observes a multiplexed 4-digit active-low 7-segment bus and rebuilds
// the 3-bit digit shown in each slot, one registered frame per full scan.
module seg7_scan_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seg_a,
    input  logic        seg_b,
    input  logic        seg_c,
    input  logic        seg_d,
    input  logic        seg_e,
    input  logic        seg_f,
    input  logic        seg_g,
    input  logic        seg_dp,
    input  logic [3:0]  an,
    output logic [11:0] digits,
    output logic [3:0]  blanks,
    output logic [3:0]  errs,
    output logic        frame_valid,
    output logic        scan_lost
);

    typedef enum logic {SETTLE, HOLD} state_t;

    localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [15:0] TO_MAX   = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [11:0] s1_q, s2_q, prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] to_q, to_d;
    logic [3:0]  mask_q, mask_d;
    logic        pend_q, pend_d;
    logic [11:0] slot_val_q, slot_val_d;
    logic [3:0]  slot_blank_q, slot_blank_d;
    logic [3:0]  slot_err_q, slot_err_d;
    logic [11:0] digits_q, digits_d;
    logic [3:0]  blanks_q, blanks_d;
    logic [3:0]  errs_q, errs_d;
    logic        fv_q, fv_d;
    logic        lost_q, lost_d;

    logic [2:0] dec_val;
    logic       dec_blank;
    logic       dec_err;
    logic [3:0] an_sel;
    logic       one_hot;
    logic       stable;
    logic       cap;
    logic       to_hit;
    logic [3:0] mask_base;

    always_comb begin
        dec_val   = 3'd0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        if (!s2_q[0]) begin
            dec_err = 1'b1;
        end else begin
            unique case (s2_q[7:1])
                7'b0000001: dec_val = 3'd0;
                7'b1001111: dec_val = 3'd1;
                7'b0010010: dec_val = 3'd2;
                7'b0000110: dec_val = 3'd3;
                7'b1001100: dec_val = 3'd4;
                7'b0100100: dec_val = 3'd5;
                7'b0100000: dec_val = 3'd6;
                7'b0001111: dec_val = 3'd7;
                7'b1111111: dec_blank = 1'b1;
                default:    dec_err = 1'b1;
            endcase
        end
    end

    assign an_sel  = ~s2_q[11:8];
    assign one_hot = $onehot(an_sel);
    assign stable  = (s2_q == prev_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap          = 1'b0;
        to_d         = to_q;
        lost_d       = lost_q;
        to_hit       = 1'b0;
        slot_val_d   = slot_val_q;
        slot_blank_d = slot_blank_q;
        slot_err_d   = slot_err_q;
        digits_d     = digits_q;
        blanks_d     = blanks_q;
        errs_d       = errs_q;
        fv_d         = pend_q;

        unique case (state_q)
            SETTLE: begin
                if (!stable) begin
                    cnt_d = 8'd0;
                end else if (cnt_q != STAB_MAX) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (stable && cnt_d == STAB_MAX && one_hot) begin
                    cap     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!stable) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd0;
                end
            end
            default: state_d = SETTLE;
        endcase

        if (cap) begin
            to_d   = 16'd0;
            lost_d = 1'b0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + 16'd1;
            if (to_d == TO_MAX) begin
                lost_d = 1'b1;
                to_hit = 1'b1;
            end
        end

        for (int i = 0; i < 4; i++) begin
            if (cap && an_sel[i]) begin
                slot_val_d[3*i +: 3] = dec_val;
                slot_blank_d[i]      = dec_blank;
                slot_err_d[i]        = dec_err;
            end
        end

        // A pending frame or a timeout restarts collection from empty
        mask_base = (pend_q || to_hit) ? 4'd0 : mask_q;
        mask_d    = mask_base | (cap ? an_sel : 4'd0);
        pend_d    = cap && (mask_d == 4'hF);

        if (pend_q) begin
            digits_d = slot_val_q;
            blanks_d = slot_blank_q;
            errs_d   = slot_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SETTLE;
            s1_q         <= '0;
            s2_q         <= '0;
            prev_q       <= '0;
            cnt_q        <= '0;
            to_q         <= '0;
            mask_q       <= '0;
            pend_q       <= 1'b0;
            slot_val_q   <= '0;
            slot_blank_q <= '0;
            slot_err_q   <= '0;
            digits_q     <= '0;
            blanks_q     <= '0;
            errs_q       <= '0;
            fv_q         <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= {an, seg_a, seg_b, seg_c, seg_d,
                             seg_e, seg_f, seg_g, seg_dp};
            s2_q         <= s1_q;
            prev_q       <= s2_q;
            cnt_q        <= cnt_d;
            to_q         <= to_d;
            mask_q       <= mask_d;
            pend_q       <= pend_d;
            slot_val_q   <= slot_val_d;
            slot_blank_q <= slot_blank_d;
            slot_err_q   <= slot_err_d;
            digits_q     <= digits_d;
            blanks_q     <= blanks_d;
            errs_q       <= errs_d;
            fv_q         <= fv_d;
            lost_q       <= lost_d;
        end
    end

    assign digits      = digits_q;
    assign blanks      = blanks_q;
    assign errs        = errs_q;
    assign frame_valid = fv_q;
    assign scan_lost   = lost_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: hand-computed frames, glitch,
// blank/illegal, bad-anode timeout and mid-frame reset scenarios.
module tb_seg7_scan_reader;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 1024;

    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PZ = 7'b0000000;

    logic        clk;
    logic        rst_n;
    logic [6:0]  pat;
    logic        dp;
    logic [3:0]  an;
    logic [11:0] digits;
    logic [3:0]  blanks;
    logic [3:0]  errs;
    logic        frame_valid;
    logic        scan_lost;

    int n_tests;
    int n_fail;
    int fv_cnt;
    int base;

    seg7_scan_reader #(
        .STABLE_CYCLES(STABLE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_a(pat[6]),
        .seg_b(pat[5]),
        .seg_c(pat[4]),
        .seg_d(pat[3]),
        .seg_e(pat[2]),
        .seg_f(pat[1]),
        .seg_g(pat[0]),
        .seg_dp(dp),
        .an(an),
        .digits(digits),
        .blanks(blanks),
        .errs(errs),
        .frame_valid(frame_valid),
        .scan_lost(scan_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial fv_cnt = 0;
    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] p,
                         input logic d);
        an  = a;
        pat = p;
        dp  = d;
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] p,
                        input logic d, input int n);
        drive(a, p, d);
        cyc(n);
    endtask

    task automatic idle(input int n);
        step(4'b1111, PB, 1'b1, n);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // 1: reset with random bus activity
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(4'($urandom), 7'($urandom), 1'($urandom));
            cyc(1);
        end
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_blanks", 32'(blanks), 32'h0);
        check("rst_errs", 32'(errs), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_lost", 32'(scan_lost), 32'h0);
        drive(4'b1111, PB, 1'b1);
        cyc(1);
        rst_n = 1'b1;
        base = fv_cnt;
        cyc(40);
        check("post_rst_lost", 32'(scan_lost), 32'h0);
        check("post_rst_digits", 32'(digits), 32'h0);
        check("post_rst_nofv", 32'(fv_cnt - base), 32'd0);

        // 2: normal scan 3,5,0,7
        base = fv_cnt;
        step(4'b1110, P3, 1'b1, 8);
        step(4'b1101, P5, 1'b1, 8);
        step(4'b1011, P0, 1'b1, 8);
        step(4'b0111, P7, 1'b1, 8);
        idle(6);
        check("scan_fv_count", 32'(fv_cnt - base), 32'd1);
        check("scan_digits", 32'(digits), 32'hE2B);
        check("scan_blanks", 32'(blanks), 32'h0);
        check("scan_errs", 32'(errs), 32'h0);

        // 3: slot 0 glitch is not captured
        base = fv_cnt;
        step(4'b1110, P1, 1'b1, STABLE - 1);
        step(4'b1101, P2, 1'b1, 8);
        step(4'b1011, P4, 1'b1, 8);
        step(4'b0111, P6, 1'b1, 8);
        idle(8);
        check("glitch_nofv", 32'(fv_cnt - base), 32'd0);
        check("glitch_hold", 32'(digits), 32'hE2B);
        step(4'b1110, P7, 1'b1, 8);
        idle(4);
        check("glitch_fv", 32'(fv_cnt - base), 32'd1);
        check("glitch_digits", 32'(digits), 32'hD17);

        // 4: blank and illegal patterns
        base = fv_cnt;
        step(4'b1110, PB, 1'b1, 8);
        step(4'b1101, PZ, 1'b1, 8);
        step(4'b1011, P0, 1'b0, 8);
        step(4'b0111, P6, 1'b1, 8);
        idle(4);
        check("bl_fv", 32'(fv_cnt - base), 32'd1);
        check("bl_digits", 32'(digits), 32'hC00);
        check("bl_blanks", 32'(blanks), 32'b0001);
        check("bl_errs", 32'(errs), 32'b0110);

        // 5: bad anodes never capture; timeout then recovery
        base = fv_cnt;
        step(4'b0000, P3, 1'b1, 20);
        step(4'b0011, P5, 1'b1, 20);
        check("badan_nofv", 32'(fv_cnt - base), 32'd0);
        check("badan_lost_early", 32'(scan_lost), 32'h0);
        begin
            int w;
            w = 0;
            while (!scan_lost && w < TIMEOUT + 50) begin
                cyc(1);
                w++;
            end
        end
        check("timeout_lost", 32'(scan_lost), 32'h1);
        check("timeout_digits", 32'(digits), 32'hC00);
        step(4'b1110, P3, 1'b1, STABLE + 1);
        check("recover_pre", 32'(scan_lost), 32'h1);
        cyc(1);
        check("recover_edge", 32'(scan_lost), 32'h0);
        cyc(2);

        // 6: reset mid-frame discards partial captures
        step(4'b1101, P5, 1'b1, 8);
        idle(2);
        rst_n = 1'b0;
        cyc(2);
        check("mid_rst_digits", 32'(digits), 32'h0);
        rst_n = 1'b1;
        base = fv_cnt;
        step(4'b1011, P2, 1'b1, 8);
        step(4'b0111, P4, 1'b1, 8);
        idle(8);
        check("mid_rst_nofv", 32'(fv_cnt - base), 32'd0);
        step(4'b1110, P1, 1'b1, 8);
        drive(4'b1101, P0, 1'b1);
        cyc(STABLE + 2);
        check("fv_lat_pre", 32'(frame_valid), 32'h0);
        cyc(1);
        check("fv_lat_pulse", 32'(frame_valid), 32'h1);
        check("mid_rst_digits2", 32'(digits), 32'h881);
        cyc(1);
        check("fv_lat_post", 32'(frame_valid), 32'h0);
        idle(4);
        check("mid_rst_fv", 32'(fv_cnt - base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
